ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_host_tx_if.sv | 12 +
 rtl/ps2_edge_detect.sv | 24 ++
 rtl/ps2_host_tx.sv | 147 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 transmitter types: FSM states, counter width and frame edge indices.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_DONE
    } tx_state_e;

    localparam int unsigned CNT_W       = 19;
    localparam logic [3:0]  PARITY_EDGE = 4'd9;
    localparam logic [3:0]  STOP_EDGE   = 4'd10;
    localparam logic [3:0]  ACK_EDGE    = 4'd11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte request/response bundle between a controller and ps2_host_tx.
interface ps2_host_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_nack;
    logic       tx_timeout;

    modport master (output tx_start, tx_data, input tx_busy, tx_done, tx_nack, tx_timeout);
    modport slave  (input tx_start, tx_data, output tx_busy, tx_done, tx_nack, tx_timeout);
endinterface

// File: rtl/ps2_edge_detect.sv
// Registered PS/2 clock level and a one-cycle falling-edge pulse (1 -> 0 on the registered level).
module ps2_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    output logic clk_lvl_o,
    output logic fall_o
);
    logic lvl_q, prev_q;

    // Idle line is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            lvl_q  <= ps2_clk_i;
            prev_q <= lvl_q;
        end
    end

    assign clk_lvl_o = lvl_q;
    assign fall_o    = prev_q & ~lvl_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 10-bit shift, ACK check.
// Optional PS2_TX_RETRY_EN: a failed frame (NACK or timeout) is re-run once with the same byte.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 2750,
    parameter int unsigned START_TIMEOUT  = 375000,
    parameter int unsigned FRAME_TIMEOUT  = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    output logic         rx_inhibit,
    ps2_host_tx_if.slave tx
);
    localparam logic [CNT_W-1:0] INH_LIM   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_LIM = CNT_W'(FRAME_TIMEOUT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       edge_q, edge_d;
    logic [9:0]       frame_q, frame_d;
    logic             nack_q, nack_d, tmo_q, tmo_d, retried_q, retried_d;
    logic             fail, clk_lvl, fall;

    ps2_edge_detect u_edge (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk_i (ps2_clk_in),
        .clk_lvl_o (clk_lvl),
        .fall_o    (fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            frame_q   <= '0;
            nack_q    <= 1'b0;
            tmo_q     <= 1'b0;
            retried_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            frame_q   <= frame_d;
            nack_q    <= nack_d;
            tmo_q     <= tmo_d;
            retried_q <= retried_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 19'd1;
        edge_d    = edge_q;
        frame_d   = frame_q;
        nack_d    = nack_q;
        tmo_d     = tmo_q;
        retried_d = retried_q;
        fail      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx.tx_start) begin
                    frame_d   = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
                    nack_d    = 1'b0;
                    tmo_d     = 1'b0;
                    retried_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: if (cnt_q == INH_LIM) state_d = S_REQ;
            S_REQ: begin
                if (fall) begin
                    edge_d  = 4'd1;
                    state_d = S_SHIFT;
                end else if (cnt_q == START_LIM) begin
                    fail  = 1'b1;
                    tmo_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    edge_d = edge_q + 4'd1;
                    if (edge_d == STOP_EDGE) state_d = S_ACK;
                end else if (cnt_q == FRAME_LIM) begin
                    fail  = 1'b1;
                    tmo_d = 1'b1;
                end
            end
            S_ACK: begin
                if (cnt_q == FRAME_LIM) begin
                    fail  = 1'b1;
                    tmo_d = 1'b1;
                end else if (edge_q != ACK_EDGE) begin
                    if (fall) begin
                        edge_d = ACK_EDGE;
                        nack_d = ps2_data_in;
                    end
                end else if (clk_lvl && ps2_data_in) begin
                    if (nack_q) fail = 1'b1;
                    else        state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            state_d = S_DONE;
            if (tmo_d) nack_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (!retried_q) begin
                state_d   = S_INHIBIT;
                retried_d = 1'b1;
                nack_d    = 1'b0;
                tmo_d     = 1'b0;
            end
`endif
        end

        // SHIFT and ACK share one frame-timeout window, so keep counting across that hop.
        if (state_d != state_q && !(state_q == S_SHIFT && state_d == S_ACK)) cnt_d = '0;
    end

    always_comb begin
        ps2_clk_oe    = 1'b0;
        ps2_data_oe   = 1'b0;
        tx.tx_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
        tx.tx_done    = (state_q == S_DONE);
        tx.tx_nack    = nack_q;
        tx.tx_timeout = tmo_q;
        rx_inhibit    = tx.tx_busy;
        unique case (state_q)
            S_INHIBIT: ps2_clk_oe  = 1'b1;
            S_REQ:     ps2_data_oe = 1'b1;
            S_SHIFT:   ps2_data_oe = ~frame_q[edge_q - 4'd1];
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench: a PS/2 device model clocks frames in; expected frames/outcomes come from queues.
module tb_ps2_host_tx;
    localparam int INH = 20, START = 200, FRAME = 400;
    localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2;

    typedef struct { logic nack; logic tmo; } exp_t;

    logic clk = 1'b0, reset = 1'b1;
    logic clk_oe, data_oe, rx_inhibit;
    logic dev_clk = 1'b1, dev_data = 1'b1;
    wire  ps2_clk_line  = dev_clk & ~clk_oe;
    wire  ps2_data_line = dev_data & ~data_oe;

    ps2_host_tx_if tx();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(START), .FRAME_TIMEOUT(FRAME)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (clk_oe),
        .ps2_data_oe (data_oe),
        .rx_inhibit  (rx_inhibit),
        .tx          (tx.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, done_seen = 0;
    exp_t       exp_q[$];
    logic [9:0] wire_exp_q[$];
    int         dev_mode_q[$];
    int         dev_fall_cnt = 0;
    bit         dev_abort = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame on the wire after the start bit: data LSB first, odd parity, stop = 1.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d};
    endfunction

    // Device model: watches for request-to-send, clocks 10 bits in, then ACKs/NACKs.
    int         dev_inh, dev_n, dev_mode;
    logic [9:0] dev_got;
    bit         dev_aborted;
    initial begin
        @(negedge clk);
        forever begin
            while (!clk_oe) @(negedge clk);
            dev_fall_cnt = 0;
            dev_inh = 0;
            while (clk_oe) begin dev_inh++; @(negedge clk); end
            chk("inhibit_len", dev_inh, INH);
            if (!data_oe) continue;
            dev_mode = (dev_mode_q.size() > 0) ? dev_mode_q.pop_front() : M_ACK;
            if (dev_mode == M_SILENT) begin
                dev_n = 0;
                while (data_oe && dev_n < 1000) begin dev_n++; @(negedge clk); end
                n_cmp++;
                if (dev_n < START || dev_n > START + 1) begin
                    n_bad++;
                    $display("FAIL req_timeout_len: got %0d expected %0d..%0d", dev_n, START, START + 1);
                end
                continue;
            end
            repeat (10) @(negedge clk);
            dev_aborted = 1'b0;
            for (int i = 0; i < 10; i++) begin
                dev_clk = 1'b0;
                dev_fall_cnt++;
                repeat (16) @(negedge clk);
                dev_clk = 1'b1;
                repeat (8) @(negedge clk);
                dev_got[i] = ps2_data_line;
                repeat (8) @(negedge clk);
                if (dev_abort) begin dev_aborted = 1'b1; break; end
            end
            if (dev_aborted) begin dev_abort = 1'b0; continue; end
            if (wire_exp_q.size() == 0) chk("wire_unexpected_frame", 1, 0);
            else                        chk("wire_frame", int'(dev_got), int'(wire_exp_q.pop_front()));
            if (dev_mode == M_ACK) dev_data = 1'b0;
            repeat (4) @(negedge clk);
            dev_clk = 1'b0;
            repeat (16) @(negedge clk);
            dev_clk = 1'b1;
            repeat (4) @(negedge clk);
            dev_data = 1'b1;
        end
    end

    // Monitor: every tx_done must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && tx.tx_done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_nack", int'(tx.tx_nack), int'(mon_e.nack));
                chk("done_timeout", int'(tx.tx_timeout), int'(mon_e.tmo));
                chk("done_busy", int'(tx.tx_busy), 0);
                chk("done_rx_inhibit", int'(rx_inhibit), 0);
                chk("done_lines", int'({clk_oe, data_oe}), 0);
            end
        end
    end

    task automatic wait_done(input int base);
        int t = 0;
        while (done_seen == base && t < 3000) begin @(negedge clk); t++; end
        if (done_seen == base) chk("done_wait_expired", 0, 1);
    endtask

    task automatic start_pulse(input logic [7:0] d);
        tx.tx_data  = d;
        tx.tx_start = 1'b1;
        @(negedge clk);
        tx.tx_start = 1'b0;
    endtask

    task automatic do_tx(input logic [7:0] d, input int m0, input int m1, input bit dup);
        int   modes[$];
        int   base;
        exp_t e;
        modes.push_back(m0);
`ifdef PS2_TX_RETRY_EN
        if (m0 != M_ACK) modes.push_back(m1);
`endif
        foreach (modes[i]) begin
            dev_mode_q.push_back(modes[i]);
            if (modes[i] != M_SILENT) wire_exp_q.push_back(frame_of(d));
        end
        e.nack = (modes[modes.size() - 1] == M_NACK);
        e.tmo  = (modes[modes.size() - 1] == M_SILENT);
        exp_q.push_back(e);
        base = done_seen;
        @(negedge clk);
        start_pulse(d);
        chk("busy_after_start", int'(tx.tx_busy), 1);
        chk("rx_inhibit_after_start", int'(rx_inhibit), 1);
        if (dup) begin
            repeat (100) @(negedge clk);
            start_pulse(8'h55);
        end
        wait_done(base);
        repeat (3) @(negedge clk);
        chk("nack_held", int'(tx.tx_nack), int'(e.nack));
        chk("timeout_held", int'(tx.tx_timeout), int'(e.tmo));
        chk("idle_busy", int'(tx.tx_busy), 0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int t;
        tx.tx_start = 1'b0;
        tx.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", int'(clk_oe), 0);
        chk("rst_data_oe", int'(data_oe), 0);
        chk("rst_busy", int'(tx.tx_busy), 0);
        chk("rst_done", int'(tx.tx_done), 0);
        chk("rst_nack", int'(tx.tx_nack), 0);
        chk("rst_timeout", int'(tx.tx_timeout), 0);
        chk("rst_rx_inhibit", int'(rx_inhibit), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        do_tx(8'hED, M_ACK, M_ACK, 1'b0);
        do_tx(8'h00, M_NACK, M_NACK, 1'b0);
        do_tx(8'($urandom), M_SILENT, M_SILENT, 1'b0);
        do_tx(8'hFF, M_ACK, M_ACK, 1'b1);

        // Reset in the middle of a frame, at the device's fifth falling edge.
        dev_mode_q.push_back(M_ACK);
        @(negedge clk);
        start_pulse(8'hA5);
        repeat (25) @(negedge clk);
        t = 0;
        while (dev_fall_cnt < 5 && t < 2000) begin @(negedge clk); t++; end
        if (dev_fall_cnt < 5) chk("edge5_wait_expired", 0, 1);
        reset     = 1'b1;
        dev_abort = 1'b1;
        @(negedge clk);
        chk("midreset_clk_oe", int'(clk_oe), 0);
        chk("midreset_data_oe", int'(data_oe), 0);
        chk("midreset_busy", int'(tx.tx_busy), 0);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        do_tx(8'hF4, M_ACK, M_ACK, 1'b0);

`ifdef PS2_TX_RETRY_EN
        do_tx(8'h3C, M_NACK, M_ACK, 1'b0);
`endif

        for (int k = 0; k < 6; k++)
            do_tx(8'($urandom), ($urandom_range(0, 2) == 0) ? M_NACK : M_ACK,
                  ($urandom_range(0, 1) == 0) ? M_NACK : M_ACK, 1'b0);

        repeat (50) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("wire_q_drained", wire_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
